// File: rtl/sel_merge_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 9-to-1 select-merge.
package sel_merge_pkg;

    localparam int unsigned N_CH  = 9;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_CH-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (oh[IDX_W'(i)]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sel_merge_arb9.sv
// Combinational 9-way grant picker for the select-merge.
// SEL_MERGE_RR_EN selects round-robin from last_idx_i+1; otherwise lowest index wins.
module sel_merge_arb9
    import sel_merge_pkg::*;
(
    input  logic [N_CH-1:0]  pending_i,
    input  logic [IDX_W-1:0] last_idx_i,
    output logic [N_CH-1:0]  grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

`ifdef SEL_MERGE_RR_EN
    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        cand    = '0;
        // Walk the ring starting one past the last winner, wrapping 8->0.
        for (int unsigned off = 1; off <= N_CH; off++) begin
            cand = IDX_W'((int unsigned'(last_idx_i) + off) % N_CH);
            if (!found && pending_i[cand]) begin
                grant_o[cand] = 1'b1;
                found         = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] unused_last;
    assign unused_last = last_idx_i;

    always_comb begin
        grant_o = pending_i & (~pending_i + N_CH'(1));
    end
`endif

    assign grant_idx_o = onehot_to_idx(grant_o);

endmodule

// File: rtl/c_sel_merge9_sync.sv
// Synchronous 9-to-1 select-merge on the drive/free pulse protocol.
// Build option SEL_MERGE_RR_EN enables round-robin grant (default: fixed priority).
module c_sel_merge9_sync
    import sel_merge_pkg::*;
#(
    parameter int unsigned FREE_DLY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  i_drive,
    output logic [N_CH-1:0]  o_free,
    output logic             o_driveNext,
    output logic [IDX_W-1:0] o_sel,
    input  logic             i_freeNext,
    output logic             o_busy,
    output logic             o_overrun
);

    localparam int unsigned CNT_W = (FREE_DLY > 1) ? $clog2(FREE_DLY) : 1;

    state_e           state_q, state_d;
    logic [N_CH-1:0]  pending_q, pending_d;
    logic [N_CH-1:0]  free_q, free_d;
    logic [N_CH-1:0]  grant_oh, inflight;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] grant_idx, last_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drv_q, drv_d;
    logic             ovr_q, ovr_d;
    logic             busy;

`ifdef SEL_MERGE_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    assign last_idx = ptr_q;

    // Pointer parks on the top index so the first search after reset begins at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IDX_W'(N_CH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign last_idx = IDX_W'(N_CH - 1);
`endif

    sel_merge_arb9 u_arb (
        .pending_i   (pending_q),
        .last_idx_i  (last_idx),
        .grant_o     (grant_oh),
        .grant_idx_o (grant_idx)
    );

    assign busy     = (state_q != IDLE);
    assign inflight = busy ? (N_CH'(1) << sel_q) : '0;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        free_d    = '0;
        drv_d     = 1'b0;
        // A repeat drive on a branch already queued or in flight only flags overrun.
        pending_d = pending_q | (i_drive & ~pending_q & ~inflight);
        ovr_d     = ovr_q | (|(i_drive & (pending_q | inflight)));
`ifdef SEL_MERGE_RR_EN
        ptr_d     = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    sel_d     = grant_idx;
                    pending_d = pending_d & ~grant_oh;
                    state_d   = DRIVE;
`ifdef SEL_MERGE_RR_EN
                    ptr_d     = grant_idx;
`endif
                end
            end
            DRIVE: begin
                drv_d   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (i_freeNext) begin
                    cnt_d   = CNT_W'(FREE_DLY - 1);
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (cnt_q == '0) begin
                    free_d  = N_CH'(1) << sel_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            free_q    <= '0;
            drv_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            free_q    <= free_d;
            drv_q     <= drv_d;
            ovr_q     <= ovr_d;
        end
    end

    assign o_free      = free_q;
    assign o_driveNext = drv_q;
    assign o_sel       = sel_q;
    assign o_busy      = busy;
    assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_c_sel_merge9_sync.sv
// Self-checking bench for c_sel_merge9_sync: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_c_sel_merge9_sync;

    localparam int FREE_DLY = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] i_drive = '0;
    logic       i_freeNext = 1'b0;
    logic [8:0] o_free;
    logic       o_driveNext;
    logic [3:0] o_sel;
    logic       o_busy;
    logic       o_overrun;

    always #5 clk = ~clk;

    c_sel_merge9_sync #(.FREE_DLY(FREE_DLY)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (i_drive),
        .o_free      (o_free),
        .o_driveNext (o_driveNext),
        .o_sel       (o_sel),
        .i_freeNext  (i_freeNext),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending set, one token record (owner, grant edge, free edge).
    logic [8:0] m_pend = '0;
    bit         m_busy = 1'b0;
    int         m_owner = 0;
    int         m_gedge = 0;
    int         m_fedge = -1;
    int         m_last = 8;
    bit         m_ovr = 1'b0;
    logic [3:0] m_sel = '0;
    int         e = 0;
    logic [8:0] x_free = '0;
    bit         x_drv = 1'b0;
    int         order[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [8:0] p);
        int idx;
`ifdef SEL_MERGE_RR_EN
        for (int k = 1; k <= 9; k++) begin
            idx = (m_last + k) % 9;
            if (((p >> idx) & 9'd1) != 9'd0) return idx;
        end
`else
        for (int k = 0; k < 9; k++) begin
            idx = k;
            if (((p >> idx) & 9'd1) != 9'd0) return idx;
        end
`endif
        return -1;
    endfunction

    task automatic step(input logic [8:0] d, input logic f, input logic r);
        logic [8:0] pre;
        logic [8:0] infl;
        int g;
        @(negedge clk);
        i_drive    = d;
        i_freeNext = f;
        rst        = r;
        @(posedge clk);
        e++;
        x_free = '0;
        x_drv  = 1'b0;
        if (r) begin
            m_pend  = '0;
            m_busy  = 1'b0;
            m_sel   = '0;
            m_ovr   = 1'b0;
            m_last  = 8;
            m_fedge = -1;
        end else begin
            pre  = m_pend;
            infl = m_busy ? (9'd1 << m_owner) : 9'd0;
            if ((d & (pre | infl)) != 9'd0) m_ovr = 1'b1;
            m_pend = pre | (d & ~pre & ~infl);
            if (!m_busy) begin
                if (pre != 9'd0) begin
                    g       = pick(pre);
                    m_pend  = m_pend & ~(9'd1 << g);
                    m_busy  = 1'b1;
                    m_owner = g;
                    m_sel   = 4'(g);
                    m_last  = g;
                    m_gedge = e;
                    m_fedge = -1;
                end
            end else if (m_fedge < 0) begin
                if (f && e >= m_gedge + 2) m_fedge = e;
            end else if (e == m_fedge + FREE_DLY) begin
                x_free = 9'd1 << m_owner;
                m_busy = 1'b0;
            end
            x_drv = m_busy && (e == m_gedge + 1);
        end
        #1;
        chk("free", o_free, x_free);
        chk("driveNext", o_driveNext, x_drv);
        chk("busy", o_busy, m_busy);
        chk("overrun", o_overrun, m_ovr);
        chk("sel", o_sel, m_sel);
    endtask

    // Answer each downstream drive with a free, re-drive masked branches on their free.
    task automatic serve(input logic [8:0] mask, input int want);
        order.delete();
        for (int n = 0; n < 200 && !(order.size() >= want && !o_busy); n++) begin
            step(o_free & mask, o_driveNext, 1'b0);
            if (o_driveNext) order.push_back(int'(o_sel));
        end
        chk("serve_count", order.size(), want);
    endtask

    int exp_fair[6];

    initial begin
        // Reset state
        step(9'h000, 1'b0, 1'b1);
        step(9'h000, 1'b0, 1'b1);
        chk("rst_free", o_free, 9'h000);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_sel", o_sel, 4'd0);

        // Single token latency
        step(9'h008, 1'b0, 1'b0);
        step(9'h000, 1'b0, 1'b0);
        step(9'h000, 1'b0, 1'b0);
        chk("t1_driveNext", o_driveNext, 1'b1);
        chk("t1_sel", o_sel, 4'd3);
        step(9'h000, 1'b1, 1'b0);
        step(9'h000, 1'b0, 1'b0);
        step(9'h000, 1'b0, 1'b0);
        chk("t1_free", o_free, 9'h008);

        // Burst of three simultaneous drives
        step(9'h000, 1'b0, 1'b1);
        step(9'h111, 1'b0, 1'b0);
        serve(9'h000, 3);
        chk("t2_order0", order[0], 0);
        chk("t2_order1", order[1], 4);
        chk("t2_order2", order[2], 8);

        // Fairness: branches 0 and 1 re-drive on their free, branch 5 waits
`ifdef SEL_MERGE_RR_EN
        exp_fair = '{0, 1, 5, 0, 1, 0};
`else
        exp_fair = '{0, 1, 0, 1, 0, 1};
`endif
        step(9'h000, 1'b0, 1'b1);
        step(9'h023, 1'b0, 1'b0);
        serve(9'h003, 6);
        for (int k = 0; k < 6; k++) chk($sformatf("t3_order%0d", k), order[k], exp_fair[k]);

        // Overrun: branch 2 driven twice before grant
        step(9'h000, 1'b0, 1'b1);
        step(9'h004, 1'b0, 1'b0);
        step(9'h004, 1'b0, 1'b0);
        chk("t4_overrun", o_overrun, 1'b1);
        serve(9'h000, 1);
        for (int k = 0; k < 5; k++) step(9'h000, 1'b0, 1'b0);
        chk("t4_overrun_sticky", o_overrun, 1'b1);
        chk("t4_busy", o_busy, 1'b0);

        // Spurious free in IDLE, then a normal token
        step(9'h000, 1'b0, 1'b1);
        step(9'h000, 1'b1, 1'b0);
        chk("t5_busy", o_busy, 1'b0);
        step(9'h000, 1'b0, 1'b0);
        chk("t5_free", o_free, 9'h000);
        step(9'h040, 1'b0, 1'b0);
        serve(9'h000, 1);
        chk("t5_sel", order[0], 6);

        // Reset while waiting for downstream free
        step(9'h080, 1'b0, 1'b0);
        step(9'h000, 1'b0, 1'b0);
        step(9'h000, 1'b0, 1'b0);
        step(9'h000, 1'b0, 1'b0);
        chk("t6_busy_pre", o_busy, 1'b1);
        step(9'h000, 1'b0, 1'b1);
        chk("t6_busy", o_busy, 1'b0);
        chk("t6_drv", o_driveNext, 1'b0);
        step(9'h000, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(9'h000, 1'b0, 1'b0);
            chk("t6_free", o_free, 9'h000);
        end

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(9'($urandom & $urandom & $urandom),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
